// File: rtl/soc_pkg.sv
// soc_pkg: shared types and constants for the 8-bit CPU core front end.
//   DATA_WIDTH / ADDR_WIDTH : datapath and program-address widths
//   INSTR_BYTES             : every instruction is opcode byte + operand byte
//   RESET_PC_DEFAULT        : program counter value after reset
//   opcode_t                : architectural opcodes (raw byte values)
//   alu_op_t                : operation selector handed to the execute stage
//   fetch_state_t           : fetch/decode sequencer states
//   dec_instr_t             : one fully decoded instruction
package soc_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int ADDR_WIDTH  = 8;
  localparam int INSTR_BYTES = 2;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = '0;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [7:0] {
    OP_NOP   = 8'h00,
    OP_LOAD  = 8'h01,
    OP_STORE = 8'h02,
    OP_ADD   = 8'h03,
    OP_SUB   = 8'h04,
    OP_JUMP  = 8'h05
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_PASS = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    S_OP_REQ  = 2'd0,
    S_ARG_REQ = 2'd1,
    S_ARG_CAP = 2'd2,
    S_OUT     = 2'd3
  } fetch_state_t;

  // The opcode field may carry a byte outside opcode_t when illegal is set;
  // the execute stage sees the raw value so it can report it when trapping.
  typedef struct packed {
    opcode_t opcode;
    alu_op_t alu_op;
    data_t   operand;
    logic    is_load;
    logic    is_store;
    logic    illegal;
  } dec_instr_t;

endpackage

// File: rtl/fetch_decode_opcode_decode.sv
// opcode_decode: purely combinational opcode -> decoded instruction mapping.
//   opcode_i  : raw opcode byte
//   operand_i : raw operand byte, passed through as the immediate / address
//   instr_o   : decoded fields for the execute stage
//   is_jump_o : opcode is OP_JUMP (consumed by the fetch unit, never emitted)
//   is_nop_o  : opcode is OP_NOP  (consumed by the fetch unit, never emitted)
module opcode_decode
  import soc_pkg::*;
(
  input  logic [7:0] opcode_i,
  input  data_t      operand_i,
  output dec_instr_t instr_o,
  output logic       is_jump_o,
  output logic       is_nop_o
);

  always_comb begin
    instr_o          = '0;
    instr_o.opcode   = opcode_t'(opcode_i);
    instr_o.alu_op   = ALU_PASS;
    instr_o.operand  = operand_i;
    instr_o.is_load  = 1'b0;
    instr_o.is_store = 1'b0;
    instr_o.illegal  = 1'b0;
    is_jump_o        = 1'b0;
    is_nop_o         = 1'b0;

    case (opcode_i)
      OP_ADD:   instr_o.alu_op   = ALU_ADD;
      OP_SUB:   instr_o.alu_op   = ALU_SUB;
      OP_LOAD:  instr_o.is_load  = 1'b1;
      OP_STORE: instr_o.is_store = 1'b1;
      OP_JUMP:  is_jump_o        = 1'b1;
      OP_NOP:   is_nop_o         = 1'b1;
      // Unknown bytes still flow downstream so the execute stage can trap.
      default:  instr_o.illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch and decode front end of the 8-bit CPU.
// Fetches 2-byte instructions (opcode, operand) from a 1-cycle-latency
// program memory, decodes them and hands one instruction at a time to the
// execute stage over a valid/ready handshake. JUMP and NOP never leave here.
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   halt_i        : suppresses the start of a new fetch
//   mem_rd_en     : program memory read strobe
//   mem_addr      : program memory address (zero when no read is issued)
//   mem_rdata     : read data, valid the cycle after mem_rd_en
//   dec_valid     : decoded instruction valid
//   dec_ready     : execute stage accepts the instruction
//   dec_opcode    : raw opcode byte
//   dec_alu_op    : alu_op_t selector
//   dec_operand   : immediate (ADD/SUB) or data address (LOAD/STORE)
//   dec_is_load   : instruction is LOAD
//   dec_is_store  : instruction is STORE
//   dec_illegal   : opcode not recognised
//   pc_o          : start address of the instruction in flight, next PC in S_OUT
module fetch_decode #(
  parameter int                    DATA_WIDTH = soc_pkg::DATA_WIDTH,
  parameter int                    ADDR_WIDTH = soc_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = soc_pkg::RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt_i,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [7:0]            dec_opcode,
  output logic [3:0]            dec_alu_op,
  output logic [DATA_WIDTH-1:0] dec_operand,
  output logic                  dec_is_load,
  output logic                  dec_is_store,
  output logic                  dec_illegal,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  import soc_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSTR_BYTES);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            opcode_q, opcode_d;
  dec_instr_t            dec_q, dec_d;
  dec_instr_t            dec_comb;
  logic                  is_jump;
  logic                  is_nop;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // The opcode byte was captured a cycle earlier; the operand is taken
  // straight from the memory bus in S_ARG_CAP so decode costs no extra cycle.
  opcode_decode u_opcode_decode (
    .opcode_i  (opcode_q),
    .operand_i (data_t'(mem_rdata)),
    .instr_o   (dec_comb),
    .is_jump_o (is_jump),
    .is_nop_o  (is_nop)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    dec_d    = dec_q;
    rd_req   = 1'b0;
    rd_addr  = '0;

    case (state_q)
      S_OP_REQ: begin
        if (!halt_i) begin
          rd_req  = 1'b1;
          rd_addr = pc_q;
          state_d = S_ARG_REQ;
        end
      end

      S_ARG_REQ: begin
        opcode_d = 8'(mem_rdata);
        rd_req   = 1'b1;
        rd_addr  = pc_q + PC_ONE;
        state_d  = S_ARG_CAP;
      end

      S_ARG_CAP: begin
        pc_d = pc_q + PC_STEP;
        if (is_jump) begin
          pc_d    = ADDR_WIDTH'(mem_rdata);
          state_d = S_OP_REQ;
        end else if (is_nop) begin
          state_d = S_OP_REQ;
        end else begin
          dec_d   = dec_comb;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (dec_ready) begin
          state_d = S_OP_REQ;
        end
      end

      default: state_d = S_OP_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OP_REQ;
      pc_q     <= RESET_PC;
      opcode_q <= '0;
      dec_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      dec_q    <= dec_d;
    end
  end

  // The read strobe is decoded from state, so it is qualified by rst_n to
  // keep the memory quiet for the whole time reset is held.
  assign mem_rd_en    = rd_req & rst_n;
  assign mem_addr     = (rd_req & rst_n) ? rd_addr : '0;

  assign dec_valid    = (state_q == S_OUT);
  assign dec_opcode   = dec_q.opcode;
  assign dec_alu_op   = dec_q.alu_op;
  assign dec_operand  = DATA_WIDTH'(dec_q.operand);
  assign dec_is_load  = dec_q.is_load;
  assign dec_is_store = dec_q.is_store;
  assign dec_illegal  = dec_q.illegal;
  assign pc_o         = pc_q;

  // A stalled instruction must not change under the execute stage.
  assert property (@(posedge clk) disable iff (!rst_n)
    (dec_valid && !dec_ready) |=> (dec_valid && $stable(dec_q)));

  // No fetch may start while an instruction is still waiting to be accepted.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_OUT) |-> !mem_rd_en);

endmodule
